// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, frame-locking arbiter that feeds byte streams
// from four requesters into a single UART transmitter. Each byte is handed to
// the transmitter as a held uart_tx_en pulse. The arbiter then tracks the
// transmitter's busy flag so that the next byte starts only after the current
// one has been sent.
module uart_tx_arbiter #(
  parameter int unsigned N_REQ        = 4,
  parameter int unsigned EN_HOLD      = 4,
  parameter int unsigned BUSY_TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]   req_last,
  output logic [N_REQ-1:0]   req_ready,
  output logic [7:0]         uart_data,
  output logic               uart_tx_en,
  input  logic               uart_tx_busy,
  output logic [1:0]         grant_id,
  output logic               grant_lock,
  output logic               err_timeout
);

  localparam int unsigned   TW        = $clog2(BUSY_TIMEOUT) + 1;
  localparam logic [TW-1:0] TO_LAST   = TW'(BUSY_TIMEOUT - 1);
  localparam logic [3:0]    HOLD_LAST = 4'(EN_HOLD - 1);

  typedef enum logic [1:0] {
    ST_ARB       = 2'd0,
    ST_LOAD      = 2'd1,
    ST_WAIT_RISE = 2'd2,
    ST_WAIT_FALL = 2'd3
  } state_t;

  state_t          state_r, state_s;
  logic [7:0]      uart_data_r, uart_data_s;
  logic            uart_tx_en_r, uart_tx_en_s;
  logic [1:0]      grant_id_r, grant_id_s;
  logic            grant_lock_r, grant_lock_s;
  logic            err_timeout_r, err_timeout_s;
  logic            last_flag_r, last_flag_s;
  logic [1:0]      last_owner_r, last_owner_s;
  logic            busy_seen_r, busy_seen_s;
  logic [3:0]      hold_cnt_r, hold_cnt_s;
  logic [TW-1:0]   to_cnt_r, to_cnt_s;
  logic [1:0]      cand_id_s;
  logic            cand_ok_s;
  logic [N_REQ-1:0] ready_s;
  logic            xfer_s;

  // Round-robin search: first valid requester starting after last_owner.
  // Walking from the farthest offset down to the nearest lets the nearest win.
  function automatic logic [2:0] rr_pick(input logic [N_REQ-1:0] valid,
                                         input logic [1:0]       owner);
    logic [2:0] pick;
    logic [1:0] idx;
    pick = 3'b000;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = owner + 2'(k);
      if (valid[idx]) begin
        pick = {1'b1, idx};
      end else begin
        pick = pick;
      end
    end
    return pick;
  endfunction

  // Candidate selection: the locked owner only, otherwise the round-robin winner.
  always_comb begin
    cand_id_s = 2'd0;
    cand_ok_s = 1'b0;
    if (grant_lock_r) begin
      cand_id_s = grant_id_r;
      cand_ok_s = req_valid[grant_id_r];
    end else begin
      {cand_ok_s, cand_id_s} = rr_pick(req_valid, last_owner_r);
    end
  end

  // Combinational ready: one-hot to the candidate, only while arbitrating.
  // Gated by rst_n so that ready is low as soon as reset is asserted.
  always_comb begin
    ready_s = {N_REQ{1'b0}};
    if (rst_n && (state_r == ST_ARB) && cand_ok_s) begin
      ready_s[cand_id_s] = 1'b1;
    end else begin
      ready_s = {N_REQ{1'b0}};
    end
  end

  assign xfer_s = |ready_s;

  // Next-state and next-register values for the byte hand-off sequence.
  always_comb begin
    state_s       = state_r;
    uart_data_s   = uart_data_r;
    uart_tx_en_s  = uart_tx_en_r;
    grant_id_s    = grant_id_r;
    grant_lock_s  = grant_lock_r;
    err_timeout_s = 1'b0;
    last_flag_s   = last_flag_r;
    last_owner_s  = last_owner_r;
    busy_seen_s   = busy_seen_r;
    hold_cnt_s    = hold_cnt_r;
    to_cnt_s      = to_cnt_r;
    case (state_r)
      ST_ARB: begin
        if (xfer_s) begin
          uart_data_s  = req_data[{cand_id_s, 3'b000} +: 8];
          uart_tx_en_s = 1'b1;
          grant_id_s   = cand_id_s;
          grant_lock_s = 1'b1;
          last_flag_s  = req_last[cand_id_s];
          busy_seen_s  = 1'b0;
          hold_cnt_s   = 4'd0;
          state_s      = ST_LOAD;
        end else begin
          uart_tx_en_s = 1'b0;
        end
      end
      ST_LOAD: begin
        busy_seen_s = busy_seen_r | uart_tx_busy;
        if (hold_cnt_r == HOLD_LAST) begin
          uart_tx_en_s = 1'b0;
          to_cnt_s     = {TW{1'b0}};
          state_s      = ST_WAIT_RISE;
        end else begin
          hold_cnt_s = hold_cnt_r + 4'd1;
        end
      end
      ST_WAIT_RISE: begin
        // A busy seen this very cycle counts, so a late rise never races the timeout.
        busy_seen_s = busy_seen_r | uart_tx_busy;
        if (busy_seen_r || uart_tx_busy) begin
          state_s = ST_WAIT_FALL;
        end else if (to_cnt_r == TO_LAST) begin
          err_timeout_s = 1'b1;
          grant_lock_s  = 1'b0;
          last_owner_s  = grant_id_r;
          state_s       = ST_ARB;
        end else begin
          to_cnt_s = to_cnt_r + TW'(1);
        end
      end
      ST_WAIT_FALL: begin
        if (!uart_tx_busy) begin
          state_s = ST_ARB;
          if (last_flag_r) begin
            grant_lock_s = 1'b0;
            last_owner_s = grant_id_r;
          end else begin
            grant_lock_s = grant_lock_r;
          end
        end else begin
          state_s = state_r;
        end
      end
      default: begin
        state_s = ST_ARB;
      end
    endcase
  end

  // State and output registers; reset leaves requester 0 first in line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_ARB;
      uart_data_r   <= 8'h00;
      uart_tx_en_r  <= 1'b0;
      grant_id_r    <= 2'd0;
      grant_lock_r  <= 1'b0;
      err_timeout_r <= 1'b0;
      last_flag_r   <= 1'b0;
      last_owner_r  <= 2'd3;
      busy_seen_r   <= 1'b0;
      hold_cnt_r    <= 4'd0;
      to_cnt_r      <= {TW{1'b0}};
    end else begin
      state_r       <= state_s;
      uart_data_r   <= uart_data_s;
      uart_tx_en_r  <= uart_tx_en_s;
      grant_id_r    <= grant_id_s;
      grant_lock_r  <= grant_lock_s;
      err_timeout_r <= err_timeout_s;
      last_flag_r   <= last_flag_s;
      last_owner_r  <= last_owner_s;
      busy_seen_r   <= busy_seen_s;
      hold_cnt_r    <= hold_cnt_s;
      to_cnt_r      <= to_cnt_s;
    end
  end

  assign req_ready   = ready_s;
  assign uart_data   = uart_data_r;
  assign uart_tx_en  = uart_tx_en_r;
  assign grant_id    = grant_id_r;
  assign grant_lock  = grant_lock_r;
  assign err_timeout = err_timeout_r;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: per-requester byte queues drive the inputs, a
// frame-level round-robin model predicts the order of bytes on the UART side,
// and a monitor compares every uart_tx_en rising edge against that prediction.
module tb_uart_tx_arbiter;

  localparam int EN_HOLD      = 4;
  localparam int BUSY_TIMEOUT = 16;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic [7:0]  uart_data;
  logic        uart_tx_en;
  logic        uart_tx_busy;
  logic [1:0]  grant_id;
  logic        grant_lock;
  logic        err_timeout;

  uart_tx_arbiter #(.N_REQ(4), .EN_HOLD(EN_HOLD), .BUSY_TIMEOUT(BUSY_TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .uart_data(uart_data),
    .uart_tx_en(uart_tx_en), .uart_tx_busy(uart_tx_busy), .grant_id(grant_id),
    .grant_lock(grant_lock), .err_timeout(err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  logic [8:0] rq [4][$];   // bytes still to be offered by each requester, bit 8 = last
  logic [8:0] mq [4][$];   // model copy of the same frames
  logic [9:0] exp_q [$];   // expected {id, data} in transmit order
  int         gap [4];
  bit         starve [4];
  int         model_last = 3;
  bit         busy_en = 1'b1;
  bit         busy_fixed = 1'b0;
  int         err_cnt = 0;
  int         cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int rq_pending();
    int n;
    n = 0;
    for (int i = 0; i < 4; i++) n += rq[i].size();
    return n;
  endfunction

  task automatic add_frame(input int id, input int len);
    logic [8:0] b;
    for (int j = 0; j < len; j++) begin
      b = {(j == len - 1), 8'($urandom)};
      rq[id].push_back(b);
      mq[id].push_back(b);
    end
  endtask

  // Frame-level round robin: whole frames go out, next owner searched after the last one.
  task automatic plan();
    int pick;
    int idx;
    logic [8:0] b;
    while ((mq[0].size() + mq[1].size() + mq[2].size() + mq[3].size()) > 0) begin
      pick = -1;
      for (int k = 1; k <= 4; k++) begin
        idx = (model_last + k) % 4;
        if (pick < 0 && mq[idx].size() > 0) pick = idx;
      end
      do begin
        b = mq[pick].pop_front();
        exp_q.push_back({2'(pick), b[7:0]});
      end while (!b[8]);
      model_last = pick;
    end
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || rq_pending() != 0) && n < 2000) begin
      @(posedge clk);
      n++;
    end
    check({name, "_drained"}, exp_q.size(), 0);
    repeat (30) @(posedge clk);
    @(negedge clk); #2;
    check({name, "_unlocked"}, grant_lock, 1'b0);
  endtask

  // Requester driver: samples transfers late in the cycle, updates just after the edge.
  initial begin : driver
    logic [3:0] xf;
    logic [8:0] b;
    for (int i = 0; i < 4; i++) begin gap[i] = 0; starve[i] = 1'b0; end
    forever begin
      @(negedge clk); #3;
      xf = req_valid & req_ready;
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++) begin
        if (xf[i] && rq[i].size() > 0) begin
          b = rq[i].pop_front();
          if (!b[8]) begin
            if (starve[i]) begin
              gap[i] = 20;
              starve[i] = 1'b0;
            end else if ($urandom_range(0, 3) == 0) begin
              gap[i] = $urandom_range(1, 6);
            end
          end
        end else if (gap[i] > 0) begin
          gap[i]--;
        end
        if (rq[i].size() > 0 && gap[i] == 0) begin
          req_valid[i] = 1'b1;
          req_data[8*i +: 8] = rq[i][0][7:0];
          req_last[i] = rq[i][0][8];
        end else begin
          req_valid[i] = 1'b0;
          req_data[8*i +: 8] = 8'h00;
          req_last[i] = 1'b0;
        end
      end
    end
  end

  // Transmitter model: busy rises a few cycles after each uart_tx_en rising edge.
  initial begin : busy_model
    int bdly;
    int blen;
    logic en_q;
    bdly = 0; blen = 0; en_q = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        uart_tx_busy = 1'b0; bdly = 0; blen = 0; en_q = 1'b0;
      end else begin
        if (uart_tx_en && !en_q && busy_en) begin
          bdly = busy_fixed ? 2 : $urandom_range(1, 3);
          blen = busy_fixed ? 8 : $urandom_range(2, 8);
        end
        if (bdly > 0) begin
          bdly--;
          if (bdly == 0) uart_tx_busy = 1'b1;
        end else if (blen > 0) begin
          blen--;
          if (blen == 0) uart_tx_busy = 1'b0;
        end
        en_q = uart_tx_en;
      end
    end
  end

  // Monitor: checks ready legality each cycle and pops the scoreboard on each new byte.
  initial begin : monitor
    logic       en_prev;
    logic       err_prev;
    int         run;
    int         fall_cyc;
    logic [7:0] held;
    logic [9:0] e;
    en_prev = 1'b0; err_prev = 1'b0; run = 0; fall_cyc = -1000; held = 8'h00;
    forever begin
      @(negedge clk); #1;
      cyc++;
      if (!rst_n) begin
        en_prev = 1'b0; err_prev = 1'b0; run = 0;
      end else begin
        if (req_ready != 4'b0000) begin
          check("ready_onehot", $countones(req_ready), 1);
          check("ready_without_valid", req_ready & ~req_valid, 4'b0000);
          if (grant_lock) check("ready_to_owner_only", req_ready, 4'b0001 << grant_id);
        end
        if (uart_tx_en && !en_prev) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_byte: got id %0d data %0h, expected no byte", grant_id, uart_data);
          end else begin
            e = exp_q.pop_front();
            check("byte_id", grant_id, e[9:8]);
            check("byte_data", uart_data, e[7:0]);
            check("lock_on_send", grant_lock, 1'b1);
          end
          held = uart_data;
          run = 1;
        end else if (uart_tx_en) begin
          run++;
          check("data_stable_during_en", uart_data, held);
        end else if (en_prev) begin
          check("en_hold_cycles", run, EN_HOLD);
          fall_cyc = cyc;
        end
        if (err_timeout) begin
          err_cnt++;
          check("err_single_pulse", err_prev, 1'b0);
          check("err_delay_after_en_fall", cyc - fall_cyc, BUSY_TIMEOUT);
          check("lock_free_on_timeout", grant_lock, 1'b0);
        end
        en_prev = uart_tx_en;
        err_prev = err_timeout;
      end
    end
  end

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int n;
    int err_start;
    rst_n = 1'b0; req_valid = 4'b0000; req_data = 32'h0; req_last = 4'b0000;
    uart_tx_busy = 1'b0;
    repeat (3) @(negedge clk); #1;
    check("rst_tx_en", uart_tx_en, 1'b0);
    check("rst_data", uart_data, 8'h00);
    check("rst_ready", req_ready, 4'b0000);
    check("rst_lock", grant_lock, 1'b0);
    check("rst_grant_id", grant_id, 2'd0);
    check("rst_err", err_timeout, 1'b0);
    @(negedge clk); rst_n = 1'b1;

    // Single byte A5 from requester 0.
    rq[0].push_back({1'b1, 8'hA5}); mq[0].push_back({1'b1, 8'hA5});
    plan();
    drain("single");

    // All four requesters busy with single-byte frames: strict rotation.
    for (int r = 0; r < 2; r++) for (int i = 0; i < 4; i++) add_frame(i, 1);
    plan();
    drain("round_robin");

    // Transmitter never goes busy: one timeout pulse, then rotation resumes after the owner.
    busy_en = 1'b0;
    err_start = err_cnt;
    add_frame(1, 1);
    plan();
    n = 0;
    while (err_cnt == err_start && n < 200) begin @(posedge clk); n++; end
    repeat (5) @(posedge clk);
    check("timeout_pulse_count", err_cnt - err_start, 1);
    busy_en = 1'b1;
    for (int i = 0; i < 4; i++) add_frame(i, 1);
    plan();
    drain("after_timeout");

    // Three-byte frame on requester 2 with a long valid gap, requester 0 waiting.
    starve[2] = 1'b1;
    add_frame(2, 3);
    add_frame(0, 1);
    plan();
    n = 0;
    while (exp_q.size() > 3 && n < 200) begin @(posedge clk); n++; end
    repeat (12) @(posedge clk);
    @(negedge clk); #2;
    check("starve_lock_held", grant_lock, 1'b1);
    check("starve_owner", grant_id, 2'd2);
    check("starve_no_ready", req_ready, 4'b0000);
    drain("frame_lock");

    // Randomized mixes of requesters, frame counts and frame lengths.
    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(1, 15);
      for (int i = 0; i < 4; i++) begin
        if (n[i]) begin
          for (int f = 0; f < $urandom_range(1, 2); f++) add_frame(i, $urandom_range(1, 4));
        end
      end
      plan();
      drain("random");
    end

    // Reset while the first byte of a three-byte frame waits for busy to fall.
    busy_fixed = 1'b1;
    err_start = err_cnt;
    add_frame(2, 3);
    plan();
    n = 0;
    while (exp_q.size() > 2 && n < 200) begin @(posedge clk); n++; end
    n = 0;
    while (!(uart_tx_busy && !uart_tx_en) && n < 200) begin @(posedge clk); n++; end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_tx_en", uart_tx_en, 1'b0);
    check("midrst_data", uart_data, 8'h00);
    check("midrst_ready", req_ready, 4'b0000);
    check("midrst_lock", grant_lock, 1'b0);
    check("midrst_grant_id", grant_id, 2'd0);
    check("midrst_err", err_timeout, 1'b0);
    for (int i = 0; i < 4; i++) begin
      rq[i].delete(); mq[i].delete(); gap[i] = 0; starve[i] = 1'b0;
    end
    exp_q.delete();
    model_last = 3;
    busy_fixed = 1'b0;
    for (int i = 0; i < 4; i++) add_frame(i, 1);
    plan();
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #2;
    check("first_edge_transfer", uart_tx_en, 1'b1);
    drain("after_reset");
    check("no_err_from_reset", err_cnt - err_start, 0);
    check("err_total", err_cnt, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, number of byte-stream requesters (fixed at 4 in this revision; indices 0..3).
REQ-002 Parameter EN_HOLD, default 4, cycles uart_tx_en is held high per byte (legal range 3..15).
REQ-003 Parameter BUSY_TIMEOUT, default 16, cycles to wait for uart_tx_busy to rise after uart_tx_en falls.
REQ-004 clk  input  1  single system clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 req_valid  input  4  bit i = requester i presents a byte.
REQ-007 req_data  input  32  byte for requester i at bits [8i+7:8i].
REQ-008 req_last  input  4  bit i = presented byte is the last of its frame.
REQ-009 req_ready  output  4  bit i = byte accepted this cycle; transfer = valid & ready at a rising edge.
REQ-010 uart_data  output  8  registered byte to the UART transmitter.
REQ-011 uart_tx_en  output  1  registered start request; the transmitter edge-detects it.
REQ-012 uart_tx_busy  input  1  transmitter busy for the full start/data/stop frame.
REQ-013 grant_id  output  2  index of the requester owning the channel; valid while grant_lock = 1.
REQ-014 grant_lock  output  1  a frame is in progress and the channel is locked to grant_id.
REQ-015 err_timeout  output  1  one-cycle pulse when busy never rose within BUSY_TIMEOUT.

Function
REQ-016 State machine states: ARB, LOAD, WAIT_RISE, WAIT_FALL; encoding is free.
REQ-017 ARB, unlocked: candidate = first i with req_valid[i] = 1, searched round-robin from (last_owner+1) mod 4.
REQ-018 ARB, locked: candidate = grant_id only; other requesters are ignored; lock is held indefinitely while grant_id's valid is low.
REQ-019 req_ready is combinational: req_ready[i] = 1 only in ARB, for i = candidate, with req_valid[i] = 1; at most one bit set.
REQ-020 On transfer: uart_data <= selected byte, uart_tx_en <= 1, grant_id <= i, grant_lock <= 1, last flag <= req_last[i], state -> LOAD.
REQ-021 LOAD: uart_tx_en stays high exactly EN_HOLD cycles, uart_data stable; then uart_tx_en <= 0, state -> WAIT_RISE, timeout counter cleared.
REQ-022 uart_data shall not change from transfer until the state re-enters ARB.
REQ-023 busy_seen flag sets on any cycle in LOAD or WAIT_RISE with uart_tx_busy = 1; cleared on transfer.
REQ-024 WAIT_RISE: busy_seen = 1 -> WAIT_FALL; else counter increments; on count = BUSY_TIMEOUT-1: err_timeout pulse, grant_lock <= 0, last_owner <= grant_id, state -> ARB.
REQ-025 WAIT_FALL: uart_tx_busy = 0 -> state ARB; if last flag = 1: grant_lock <= 0, last_owner <= grant_id; else lock retained.
REQ-026 Minimum one full cycle in ARB between bytes; uart_tx_en is low for at least that cycle, guaranteeing a fresh rising edge.
REQ-027 Simultaneous valids when unlocked: only the round-robin winner is served; losers see req_ready = 0 and must hold data.
REQ-028 req_valid deasserted by a non-granted requester has no effect; a valid raised mid-frame by another requester waits for lock release.
REQ-029 Timeout counter width is clog2(BUSY_TIMEOUT)+1 bits; no wrap-around before the compare fires.

Reset
REQ-030 On rst_n = 0, immediately and independent of clk: state ARB, uart_tx_en 0, uart_data 8'h00, req_ready 0, grant_lock 0, grant_id 0, err_timeout 0, busy_seen 0, counters 0, last_owner 3 (requester 0 first priority).
REQ-031 Reset asserted mid-frame abandons the frame; the remaining bytes are not sent and no err_timeout is issued.
REQ-032 After rst_n rises, the first transfer can occur on the first rising edge.

Verification
REQ-033 Single byte: req_valid=4'b0001, data 8'hA5, last=1, busy model rises 2 cycles after en -> ready[0] one cycle, uart_tx_en high 4 cycles, uart_data=A5, lock released after busy falls.
REQ-034 Round-robin: all four valid continuously with last=1 -> served order 0,1,2,3,0; exactly one ready bit per byte.
REQ-035 Frame lock: req 2 sends 3 bytes (last on third) while req 0 valid -> bytes 2,2,2 then 0; grant_id=2 throughout the frame.
REQ-036 Timeout: busy held 0 -> err_timeout one pulse BUSY_TIMEOUT cycles after en falls, grant_lock 0, next winner is the following requester.
REQ-037 Reset mid-frame: rst_n low during WAIT_FALL of byte 1 of 3 -> all outputs at reset values same cycle; after release req 0 wins first.
REQ-038 Starved valid: locked requester drops valid for 20 cycles -> lock held, no ready to others, resumes on valid.
